// File: rtl/ex_mem_stage_if.sv
// EX -> EX/MEM boundary bundle: execute results and controls flowing in,
// registered EX/MEM state, redirect and halt status flowing out.
interface ex_mem_stage_if #(
    parameter int DATA_W = 16
);
    logic              stall;
    logic              valid_id_ex;
    logic [4:0]        instr_op;
    logic [DATA_W-1:0] ALU_result;
    logic [DATA_W-1:0] branch_result;
    logic [DATA_W-1:0] jump_out;
    logic [DATA_W-1:0] store_data;
    logic              zero;
    logic              ltz;
    logic              err;
    logic [2:0]        Rd_id_ex;
    logic              Rd_valid_id_ex;
    logic              WriteReg_id_ex;
    logic              MemWrite_id_ex;
    logic              MemRead_id_ex;

    logic [DATA_W-1:0] ALU_result_ex_mem;
    logic [DATA_W-1:0] store_data_ex_mem;
    logic [2:0]        Rd_ex_mem;
    logic              Rd_valid_ex_mem;
    logic              WriteReg_ex_mem;
    logic              MemWrite_ex_mem;
    logic              MemRead_ex_mem;
    logic              valid_ex_mem;
    logic              redirect;
    logic [DATA_W-1:0] redirect_pc;
    logic              flush_front;
    logic              halt_ex_mem;
    logic              err_ex_mem;

    // Execute side / environment: drives the EX results, observes EX/MEM.
    modport master (
        output stall, valid_id_ex, instr_op, ALU_result, branch_result, jump_out,
               store_data, zero, ltz, err, Rd_id_ex, Rd_valid_id_ex,
               WriteReg_id_ex, MemWrite_id_ex, MemRead_id_ex,
        input  ALU_result_ex_mem, store_data_ex_mem, Rd_ex_mem, Rd_valid_ex_mem,
               WriteReg_ex_mem, MemWrite_ex_mem, MemRead_ex_mem, valid_ex_mem,
               redirect, redirect_pc, flush_front, halt_ex_mem, err_ex_mem
    );

    // The EX/MEM register itself.
    modport slave (
        input  stall, valid_id_ex, instr_op, ALU_result, branch_result, jump_out,
               store_data, zero, ltz, err, Rd_id_ex, Rd_valid_id_ex,
               WriteReg_id_ex, MemWrite_id_ex, MemRead_id_ex,
        output ALU_result_ex_mem, store_data_ex_mem, Rd_ex_mem, Rd_valid_ex_mem,
               WriteReg_ex_mem, MemWrite_ex_mem, MemRead_ex_mem, valid_ex_mem,
               redirect, redirect_pc, flush_front, halt_ex_mem, err_ex_mem
    );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, registered front-end
// redirect, wrong-path squashing and a sticky halt state.
module ex_mem_stage #(
    parameter int SQUASH_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    ex_mem_stage_if.slave bus
);
    localparam logic [4:0] OP_HALT = 5'b00000;
    localparam logic [4:0] OP_J    = 5'b00100;
    localparam logic [4:0] OP_JR   = 5'b00101;
    localparam logic [4:0] OP_JAL  = 5'b00110;
    localparam logic [4:0] OP_JALR = 5'b00111;
    localparam logic [4:0] OP_BEQZ = 5'b01100;
    localparam logic [4:0] OP_BNEZ = 5'b01101;
    localparam logic [4:0] OP_BLTZ = 5'b01110;
    localparam logic [4:0] OP_BGEZ = 5'b01111;

    localparam logic [2:0] SQ_LOAD = 3'(SQUASH_CYCLES);

    typedef enum logic [1:0] {RUN, SQUASH, HALT} state_t;

    state_t      state;
    logic [2:0]  sq_cnt;
    logic        ev;
    logic        taken;
    logic [15:0] target;
    logic        capture;

    assign capture = !bus.stall;

    // Resolve the instruction in EX: effective valid, taken flag and target.
    always_comb begin
        ev     = bus.valid_id_ex && (state == RUN);
        taken  = 1'b0;
        target = bus.branch_result;
        case (bus.instr_op)
            OP_BEQZ: taken = bus.zero;
            OP_BNEZ: taken = !bus.zero;
            OP_BLTZ: taken = bus.ltz;
            OP_BGEZ: taken = !bus.ltz;
            OP_J, OP_JR, OP_JAL, OP_JALR: begin
                taken  = 1'b1;
                target = bus.jump_out;
            end
            default: ;
        endcase
    end

    // Redirect pulse: set by a taken capture, cleared on every other edge
    // (stalled or not) so it never lasts more than one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.redirect <= 1'b0;
        end else begin
            bus.redirect <= capture && ev && !bus.err && taken;
        end
    end

    assign bus.flush_front = bus.redirect;

    // Pipeline capture plus RUN/SQUASH/HALT control, advancing only on capture edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= RUN;
            sq_cnt                <= 3'd0;
            bus.ALU_result_ex_mem <= '0;
            bus.store_data_ex_mem <= '0;
            bus.Rd_ex_mem         <= 3'd0;
            bus.Rd_valid_ex_mem   <= 1'b0;
            bus.WriteReg_ex_mem   <= 1'b0;
            bus.MemWrite_ex_mem   <= 1'b0;
            bus.MemRead_ex_mem    <= 1'b0;
            bus.valid_ex_mem      <= 1'b0;
            bus.redirect_pc       <= '0;
            bus.halt_ex_mem       <= 1'b0;
            bus.err_ex_mem        <= 1'b0;
        end else if (capture) begin
            // Data passes through unconditionally; bubbles are marked by the controls.
            bus.ALU_result_ex_mem <= bus.ALU_result;
            bus.store_data_ex_mem <= bus.store_data;
            bus.Rd_ex_mem         <= bus.Rd_id_ex;
            bus.Rd_valid_ex_mem   <= ev && bus.Rd_valid_id_ex;
            bus.WriteReg_ex_mem   <= ev && bus.WriteReg_id_ex;
            bus.MemWrite_ex_mem   <= ev && bus.MemWrite_id_ex;
            bus.MemRead_ex_mem    <= ev && bus.MemRead_id_ex;
            bus.valid_ex_mem      <= ev;

            case (state)
                RUN: begin
                    if (ev) begin
                        // An execute error outranks both HALT and a taken branch.
                        if (bus.err) begin
                            bus.halt_ex_mem <= 1'b1;
                            bus.err_ex_mem  <= 1'b1;
                            state           <= HALT;
                        end else if (bus.instr_op == OP_HALT) begin
                            bus.halt_ex_mem <= 1'b1;
                            state           <= HALT;
                        end else if (taken) begin
                            bus.redirect_pc <= target;
                            sq_cnt          <= SQ_LOAD;
                            state           <= SQUASH;
                        end
                    end
                end
                SQUASH: begin
                    sq_cnt <= sq_cnt - 3'd1;
                    if (sq_cnt == 3'd1) begin
                        state <= RUN;
                    end
                end
                HALT: ;
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: the stimulus side predicts each capture
// with an instruction-level model and queues it; a monitor checks the DUT
// after every rising edge.
module tb_ex_mem_stage;
    localparam int SQ = 2;

    logic clk;
    logic rst_n;

    ex_mem_stage_if bus ();

    ex_mem_stage #(.SQUASH_CYCLES(SQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [15:0] alu, br, jmp, sd;
        bit          z, l, e;
        logic [2:0]  rd;
        bit          rdv, wr, mw, mr, v;
    } ex_t;

    typedef struct {
        bit          v, rdv, wr, mw, mr;
        logic [15:0] alu, sd;
        logic [2:0]  rd;
        bit          redir;
        logic [15:0] rpc;
        bit          halt, err;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t last_exp;

    // Instruction-level model state
    int          sq_left;
    bit          halted, herr;
    logic [15:0] pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp(input exp_t e);
        chk("valid", 32'(bus.valid_ex_mem), 32'(e.v));
        chk("rd_valid", 32'(bus.Rd_valid_ex_mem), 32'(e.rdv));
        chk("write_reg", 32'(bus.WriteReg_ex_mem), 32'(e.wr));
        chk("mem_write", 32'(bus.MemWrite_ex_mem), 32'(e.mw));
        chk("mem_read", 32'(bus.MemRead_ex_mem), 32'(e.mr));
        chk("redirect", 32'(bus.redirect), 32'(e.redir));
        chk("flush_front", 32'(bus.flush_front), 32'(e.redir));
        chk("redirect_pc", 32'(bus.redirect_pc), 32'(e.rpc));
        chk("halt", 32'(bus.halt_ex_mem), 32'(e.halt));
        chk("err", 32'(bus.err_ex_mem), 32'(e.err));
        if (e.v) begin
            chk("alu_result", 32'(bus.ALU_result_ex_mem), 32'(e.alu));
            chk("store_data", 32'(bus.store_data_ex_mem), 32'(e.sd));
            chk("rd", 32'(bus.Rd_ex_mem), 32'(e.rd));
        end
    endtask

    // Predict what one capture of instruction x produces.
    task automatic predict(input ex_t x, output exp_t e);
        bit          live, tk;
        logic [15:0] tg;
        live = x.v && !halted && (sq_left == 0);
        e = '{default: 0};
        if (!live) begin
            if (sq_left > 0) sq_left--;
        end else begin
            e.v = 1; e.rdv = x.rdv; e.wr = x.wr; e.mw = x.mw; e.mr = x.mr;
            e.alu = x.alu; e.sd = x.sd; e.rd = x.rd;
            tk = 0; tg = x.br;
            if (x.op == 5'd12) tk = x.z;
            if (x.op == 5'd13) tk = !x.z;
            if (x.op == 5'd14) tk = x.l;
            if (x.op == 5'd15) tk = !x.l;
            if (x.op >= 5'd4 && x.op <= 5'd7) begin tk = 1; tg = x.jmp; end
            if (x.e) begin
                halted = 1; herr = 1;
            end else if (x.op == 5'd0) begin
                halted = 1;
            end else if (tk) begin
                e.redir = 1; pc = tg; sq_left = SQ;
            end
        end
        e.rpc = pc; e.halt = halted; e.err = herr;
    endtask

    // Apply one instruction at the falling edge; queue the prediction if it will be captured.
    task automatic drive(input ex_t x, input bit st);
        exp_t e;
        @(negedge clk);
        bus.stall = st;          bus.valid_id_ex = x.v;     bus.instr_op = x.op;
        bus.ALU_result = x.alu;  bus.branch_result = x.br;  bus.jump_out = x.jmp;
        bus.store_data = x.sd;   bus.zero = x.z;            bus.ltz = x.l;
        bus.err = x.e;           bus.Rd_id_ex = x.rd;       bus.Rd_valid_id_ex = x.rdv;
        bus.WriteReg_id_ex = x.wr; bus.MemWrite_id_ex = x.mw; bus.MemRead_id_ex = x.mr;
        if (!st) begin
            predict(x, e);
            sb.push_back(e);
        end
    endtask

    function automatic ex_t nop();
        ex_t x;
        x = '{default: 0};
        x.op = 5'b11001;
        return x;
    endfunction

    function automatic ex_t add(input logic [15:0] alu, input logic [2:0] rd);
        ex_t x;
        x = nop();
        x.v = 1; x.alu = alu; x.rd = rd; x.rdv = 1; x.wr = 1; x.sd = ~alu;
        return x;
    endfunction

    function automatic ex_t rnd();
        ex_t x;
        x.op = 5'($urandom_range(0, 31));
        if (x.op == 5'd0 && $urandom_range(0, 3) != 0) x.op = 5'b11001;
        x.alu = 16'($urandom); x.br = 16'($urandom); x.jmp = 16'($urandom);
        x.sd = 16'($urandom); x.z = 1'($urandom); x.l = 1'($urandom);
        x.e = ($urandom_range(0, 40) == 0); x.rd = 3'($urandom);
        x.rdv = 1'($urandom); x.wr = 1'($urandom); x.mw = 1'($urandom);
        x.mr = 1'($urandom); x.v = ($urandom_range(0, 7) != 0);
        return x;
    endfunction

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(bus.valid_ex_mem), 0);
        chk({tag, "_ctrl"}, 32'({bus.Rd_valid_ex_mem, bus.WriteReg_ex_mem,
                                bus.MemWrite_ex_mem, bus.MemRead_ex_mem}), 0);
        chk({tag, "_data"}, {bus.ALU_result_ex_mem, bus.store_data_ex_mem}, 0);
        chk({tag, "_rd"}, 32'(bus.Rd_ex_mem), 0);
        chk({tag, "_redirect"}, 32'({bus.redirect, bus.flush_front}), 0);
        chk({tag, "_redirect_pc"}, 32'(bus.redirect_pc), 0);
        chk({tag, "_halt_err"}, 32'({bus.halt_ex_mem, bus.err_ex_mem}), 0);
    endtask

    // Mid-cycle asynchronous reset, checked immediately, then released at a falling edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        sq_left = 0; halted = 0; herr = 0; pc = '0;
        sb.delete();
        last_exp = '{default: 0};
        bus.stall = 1'b1;
        bus.valid_id_ex = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: after each edge, pop and compare on a capture, else expect held outputs.
    initial begin
        forever begin
            bit cap, act;
            exp_t e;
            @(posedge clk);
            act = rst_n;
            cap = rst_n && !bus.stall;
            #1;
            if (act) begin
                if (cap) begin
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        cmp(e);
                        last_exp = e;
                    end
                end else begin
                    e = last_exp;
                    e.redir = 0;
                    cmp(e);
                    last_exp = e;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ex_t x;
        rst_n = 1'b0;
        sq_left = 0; halted = 0; herr = 0; pc = '0;
        last_exp = '{default: 0};
        bus.stall = 1'b1; bus.valid_id_ex = 0; bus.instr_op = '0;
        bus.ALU_result = '0; bus.branch_result = '0; bus.jump_out = '0;
        bus.store_data = '0; bus.zero = 0; bus.ltz = 0; bus.err = 0;
        bus.Rd_id_ex = '0; bus.Rd_valid_id_ex = 0; bus.WriteReg_id_ex = 0;
        bus.MemWrite_id_ex = 0; bus.MemRead_id_ex = 0;
        #2;
        check_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU pass-through
        drive(add(16'h1234, 3'd3), 0);
        drive(nop(), 0);

        // BEQZ taken, then three valid instructions: two squashed, third live
        x = nop(); x.v = 1; x.op = 5'b01100; x.z = 1; x.br = 16'h0040;
        drive(x, 0);
        for (int i = 0; i < 3; i++) drive(add(16'h0100 + 16'(i), 3'(i)), 0);

        // BNEZ with zero=1: not taken, followers live
        x = nop(); x.v = 1; x.op = 5'b01101; x.z = 1; x.br = 16'h0badd;
        drive(x, 0);
        drive(add(16'h0aaa, 3'd5), 0);

        // JR taken then 3 stalled cycles, then followers
        x = nop(); x.v = 1; x.op = 5'b00101; x.jmp = 16'h0100; x.br = 16'h0077;
        drive(x, 0);
        for (int i = 0; i < 3; i++) drive(add(16'h0200, 3'd1), 1);
        for (int i = 0; i < 3; i++) drive(add(16'h0300 + 16'(i), 3'd2), 0);

        // Taken jump, then reset while redirect is high
        x = nop(); x.v = 1; x.op = 5'b00110; x.jmp = 16'hfffe;
        drive(x, 0);
        do_reset();

        // HALT: sticky, later captures bubbles
        x = nop(); x.v = 1; x.op = 5'b00000;
        drive(x, 0);
        for (int i = 0; i < 3; i++) drive(add(16'h0400, 3'd4), 0);
        do_reset();

        // Taken BEQZ with err: halt with error, no redirect
        x = nop(); x.v = 1; x.op = 5'b01100; x.z = 1; x.e = 1; x.br = 16'h0040;
        drive(x, 0);
        for (int i = 0; i < 2; i++) drive(add(16'h0500, 3'd6), 0);
        do_reset();

        // Randomized traffic with random stalls and periodic resets
        for (int i = 0; i < 600; i++) begin
            drive(rnd(), ($urandom_range(0, 3) == 0));
            if (i % 75 == 74) do_reset();
        end

        drive(nop(), 1);
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
